// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - UDP receive stage: header parse, port filter, payload forward
//
// Purpose:
//   Sits downstream of the IPv4 RX stage. Parses the 8-byte UDP header
//   (4 beats at 16 bits) and filters on destination and, optionally, source port.
//   Packets flagged with an IPv4 header checksum error are dropped.
//   The payload is forwarded with one registered cycle of latency, and the
//   received byte count is checked against the UDP length field.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   valid_i / start_i / term_i input beat qualifiers (start = UDP src port beat)
//   term_len_i, len_i          bytes valid on term / non-term beats
//   cancel_i                   abort current packet
//   cs_err_i                   IPv4 header checksum error (start beat only)
//   data_i                     input data, data_i[7:0] is first on the wire
//   valid_o / start_o / term_o payload beat qualifiers
//   term_len_o, len_o, data_o  payload beat contents
//   cancel_o                   registered cancel_i or internal abort
//   src_port_o                 source port of the forwarded packet
//   len_err_o                  byte count != UDP length - 8, on term_o
//   drop_o                     1-cycle pulse when a packet is filtered
module udp_rx #(
    parameter int          DATA_W         = 16,
    parameter bit          MATCH_DST_PORT = 1'b1,
    parameter logic [15:0] DST_PORT       = 16'd18000,
    parameter bit          MATCH_SRC_PORT = 1'b0,
    parameter logic [15:0] SRC_PORT       = 16'd0,
    localparam int         LEN_W          = $clog2(DATA_W/8+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic              term_i,
    input  logic [LEN_W-1:0]  term_len_i,
    input  logic              cancel_i,
    input  logic              cs_err_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              term_o,
    output logic [LEN_W-1:0]  term_len_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              cancel_o,
    output logic [15:0]       src_port_o,
    output logic              len_err_o,
    output logic              drop_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_DATA = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t              r_state, w_nxt_state;
    logic [1:0]          r_hcnt, w_nxt_hcnt;
    logic [15:0]         r_pcnt, w_nxt_pcnt;
    logic [15:0]         r_udp_len, w_nxt_udp_len;
    logic [15:0]         r_src_cap, w_nxt_src_cap;
    logic                r_first, w_nxt_first;

    logic                r_valid, w_nxt_valid;
    logic                r_start, w_nxt_start;
    logic                r_term, w_nxt_term;
    logic [LEN_W-1:0]    r_term_len, w_nxt_term_len;
    logic [DATA_W-1:0]   r_data, w_nxt_data;
    logic [LEN_W-1:0]    r_len, w_nxt_len;
    logic                r_cancel, w_nxt_cancel;
    logic [15:0]         r_src_port, w_nxt_src_port;
    logic                r_len_err, w_nxt_len_err;
    logic                r_drop, w_nxt_drop;

    // Header fields are big-endian: first wire byte is the MSB.
    logic [15:0] w_field;
    logic [16:0] w_pcnt_sum;
    logic [16:0] w_total;
    logic [16:0] w_expect;

    assign w_field    = {data_i[7:0], data_i[15:8]};
    assign w_pcnt_sum = {1'b0, r_pcnt} + 17'(len_i);
    assign w_total    = {1'b0, r_pcnt} + 17'(term_len_i);
    assign w_expect   = {1'b0, r_udp_len - 16'd8};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hcnt     <= 2'd0;
            r_pcnt     <= 16'd0;
            r_udp_len  <= 16'd0;
            r_src_cap  <= 16'd0;
            r_first    <= 1'b0;
            r_valid    <= 1'b0;
            r_start    <= 1'b0;
            r_term     <= 1'b0;
            r_term_len <= '0;
            r_data     <= '0;
            r_len      <= '0;
            r_cancel   <= 1'b0;
            r_src_port <= 16'd0;
            r_len_err  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_hcnt     <= w_nxt_hcnt;
            r_pcnt     <= w_nxt_pcnt;
            r_udp_len  <= w_nxt_udp_len;
            r_src_cap  <= w_nxt_src_cap;
            r_first    <= w_nxt_first;
            r_valid    <= w_nxt_valid;
            r_start    <= w_nxt_start;
            r_term     <= w_nxt_term;
            r_term_len <= w_nxt_term_len;
            r_data     <= w_nxt_data;
            r_len      <= w_nxt_len;
            r_cancel   <= w_nxt_cancel;
            r_src_port <= w_nxt_src_port;
            r_len_err  <= w_nxt_len_err;
            r_drop     <= w_nxt_drop;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_hcnt     = r_hcnt;
        w_nxt_pcnt     = r_pcnt;
        w_nxt_udp_len  = r_udp_len;
        w_nxt_src_cap  = r_src_cap;
        w_nxt_first    = r_first;
        w_nxt_valid    = 1'b0;
        w_nxt_start    = 1'b0;
        w_nxt_term     = 1'b0;
        w_nxt_term_len = '0;
        w_nxt_data     = '0;
        w_nxt_len      = '0;
        w_nxt_cancel   = 1'b0;
        w_nxt_src_port = r_src_port;
        w_nxt_len_err  = 1'b0;
        w_nxt_drop     = 1'b0;

        if (cancel_i) begin
            // Cancel wins over everything, including a simultaneous start.
            w_nxt_state  = S_IDLE;
            w_nxt_cancel = 1'b1;
        end else if (valid_i && start_i) begin
            // A start in any state restarts parsing; downstream only needs
            // to be told if it has already seen payload of the old packet.
            w_nxt_cancel  = (r_state == S_DATA);
            w_nxt_src_cap = w_field;
            w_nxt_hcnt    = 2'd1;
            if (term_i) begin
                w_nxt_state = S_IDLE;
                w_nxt_drop  = 1'b1;
            end else if (cs_err_i || (MATCH_SRC_PORT && (w_field != SRC_PORT))) begin
                w_nxt_state = S_DROP;
                w_nxt_drop  = 1'b1;
            end else begin
                w_nxt_state = S_HEAD;
            end
        end else if (valid_i) begin
            case (r_state)
                S_HEAD: begin
                    case (r_hcnt)
                        2'd1: begin
                            if (term_i) begin
                                w_nxt_state = S_IDLE;
                                w_nxt_drop  = 1'b1;
                            end else if (MATCH_DST_PORT && (w_field != DST_PORT)) begin
                                w_nxt_state = S_DROP;
                                w_nxt_drop  = 1'b1;
                            end else begin
                                w_nxt_hcnt = 2'd2;
                            end
                        end
                        2'd2: begin
                            w_nxt_udp_len = w_field;
                            if (term_i) begin
                                w_nxt_state = S_IDLE;
                                w_nxt_drop  = 1'b1;
                            end else if (w_field < 16'd8) begin
                                w_nxt_state = S_DROP;
                                w_nxt_drop  = 1'b1;
                            end else begin
                                w_nxt_hcnt = 2'd3;
                            end
                        end
                        2'd3: begin
                            // UDP checksum beat, not verified. A term here
                            // is a legal empty datagram: nothing to forward.
                            w_nxt_hcnt = 2'd0;
                            if (term_i) begin
                                w_nxt_state = S_IDLE;
                            end else begin
                                w_nxt_state = S_DATA;
                                w_nxt_pcnt  = 16'd0;
                                w_nxt_first = 1'b1;
                            end
                        end
                        default: w_nxt_state = S_IDLE;
                    endcase
                end
                S_DATA: begin
                    w_nxt_valid = 1'b1;
                    w_nxt_start = r_first;
                    w_nxt_data  = data_i;
                    w_nxt_first = 1'b0;
                    if (r_first) begin
                        w_nxt_src_port = r_src_cap;
                    end
                    if (term_i) begin
                        w_nxt_state    = S_IDLE;
                        w_nxt_term     = 1'b1;
                        w_nxt_term_len = term_len_i;
                        w_nxt_len      = term_len_i;
                        w_nxt_len_err  = (w_total != w_expect);
                    end else begin
                        w_nxt_len  = len_i;
                        w_nxt_pcnt = w_pcnt_sum[16] ? 16'hFFFF : w_pcnt_sum[15:0];
                    end
                end
                S_DROP: begin
                    if (term_i) begin
                        w_nxt_state = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_o    = r_valid;
    assign start_o    = r_start;
    assign term_o     = r_term;
    assign term_len_o = r_term_len;
    assign data_o     = r_data;
    assign len_o      = r_len;
    assign cancel_o   = r_cancel;
    assign src_port_o = r_src_port;
    assign len_err_o  = r_len_err;
    assign drop_o     = r_drop;

endmodule

// File: tb/tb_udp_rx.sv
// tb/tb_udp_rx.sv - self-checking bench for udp_rx
module tb_udp_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, start_i, term_i, cancel_i, cs_err_i;
    logic [1:0]  term_len_i, len_i;
    logic [15:0] data_i;
    logic        valid_o, start_o, term_o, cancel_o, len_err_o, drop_o;
    logic [1:0]  term_len_o, len_o;
    logic [15:0] data_o, src_port_o;

    udp_rx dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .start_i    (start_i),
        .term_i     (term_i),
        .term_len_i (term_len_i),
        .cancel_i   (cancel_i),
        .cs_err_i   (cs_err_i),
        .data_i     (data_i),
        .len_i      (len_i),
        .valid_o    (valid_o),
        .start_o    (start_o),
        .term_o     (term_o),
        .term_len_o (term_len_o),
        .data_o     (data_o),
        .len_o      (len_o),
        .cancel_o   (cancel_o),
        .src_port_o (src_port_o),
        .len_err_o  (len_err_o),
        .drop_o     (drop_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        t;
        logic [1:0]  tl;
        logic [1:0]  l;
        logic        le;
    } obeat_t;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    obeat_t      mq[$];
    int          n_drop = 0;
    int          n_cancel = 0;
    int          drop_cyc = 0;
    int          b_mq, b_drop, b_cancel;
    int          st_cyc;
    logic [7:0]  pay[$];
    logic [15:0] exp_src;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) mq.push_back({data_o, start_o, term_o, term_len_o, len_o, len_err_o});
        if (drop_o) begin
            n_drop   = n_drop + 1;
            drop_cyc = cyc;
        end
        if (cancel_o) n_cancel = n_cancel + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit s, input bit t, input logic [1:0] tl,
                        input logic [15:0] d, input bit cs, input bit cx);
        valid_i = 1'b1; start_i = s; term_i = t; term_len_i = tl;
        data_i = d; cs_err_i = cs; cancel_i = cx; len_i = 2'd2;
        @(posedge clk);
        #1;
        valid_i = 1'b0; start_i = 1'b0; term_i = 1'b0; term_len_i = 2'd0;
        cs_err_i = 1'b0; cancel_i = 1'b0;
    endtask

    task automatic snap();
        b_mq = mq.size(); b_drop = n_drop; b_cancel = n_cancel;
    endtask

    task automatic mk_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // Serialise header + pay[] into 16-bit beats, first wire byte in [7:0].
    task automatic send_pkt(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] ulen, input bit cs, input bit stalls);
        logic [7:0] b[$];
        int nb;
        logic [7:0] hi;
        bit last;
        b = {src[15:8], src[7:0], dst[15:8], dst[7:0], ulen[15:8], ulen[7:0],
             8'($urandom), 8'($urandom)};
        foreach (pay[i]) b.push_back(pay[i]);
        nb = (b.size() + 1) / 2;
        for (int i = 0; i < nb; i++) begin
            if (stalls) idle($urandom_range(0, 2));
            hi   = (2*i+1 < b.size()) ? b[2*i+1] : 8'($urandom);
            last = (i == nb - 1);
            beat(i == 0, last, (last && (b.size() % 2 == 1)) ? 2'd1 : 2'd2,
                 {hi, b[2*i]}, (i == 0) ? cs : 1'b0, 1'b0);
            if (i == 0) st_cyc = cyc;
        end
        idle(3);
    endtask

    task automatic send_head(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] ulen);
        beat(1'b1, 1'b0, 2'd0, {src[7:0], src[15:8]}, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 2'd0, {dst[7:0], dst[15:8]}, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 2'd0, {ulen[7:0], ulen[15:8]}, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 2'd0, 16'($urandom), 1'b0, 1'b0);
    endtask

    // Reference: a packet is forwarded iff it passes the filters and has
    // payload; the forwarded byte stream must equal pay[].
    task automatic check_pkt(input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] ulen, input bit cs, input int exp_cancel);
        bit dropped, fwd, want_le;
        int nb, npay, ns, nt, nle, k, bad;
        logic [7:0] got[$];
        obeat_t ob;
        npay    = pay.size();
        dropped = cs || (dst != 16'd18000) || (ulen < 16'd8);
        fwd     = !dropped && (npay > 0);
        want_le = (npay != int'(ulen) - 8);
        nb      = mq.size() - b_mq;
        chk("drop_cnt", 32'(n_drop - b_drop), 32'(dropped));
        chk("cancel_cnt", 32'(n_cancel - b_cancel), 32'(exp_cancel));
        chk("beats", 32'(nb), fwd ? 32'((npay + 1) / 2) : 32'd0);
        if (fwd && nb > 0) begin
            ns = 0; nt = 0; nle = 0; bad = 0;
            for (int i = b_mq; i < mq.size(); i++) begin
                ob = mq[i];
                k  = ob.t ? int'(ob.tl) : int'(ob.l);
                got.push_back(ob.d[7:0]);
                if (k == 2) got.push_back(ob.d[15:8]);
                ns += int'(ob.s); nt += int'(ob.t); nle += int'(ob.le);
            end
            chk("first_start", 32'(mq[b_mq].s), 32'd1);
            chk("last_term", 32'(mq[mq.size()-1].t), 32'd1);
            chk("n_start", 32'(ns), 32'd1);
            chk("n_term", 32'(nt), 32'd1);
            chk("term_len", 32'(mq[mq.size()-1].tl), (npay % 2 == 1) ? 32'd1 : 32'd2);
            chk("len_err", 32'(mq[mq.size()-1].le), 32'(want_le));
            chk("n_len_err", 32'(nle), 32'(want_le));
            chk("nbytes", 32'(got.size()), 32'(npay));
            for (int j = 0; j < npay && j < got.size(); j++)
                if (got[j] !== pay[j]) bad++;
            chk("payload", 32'(bad), 32'd0);
            exp_src = src;
        end
        chk("src_port", 32'(src_port_o), 32'(exp_src));
    endtask

    initial begin
        logic [15:0] r_src, r_dst, r_len;
        int np, mode;
        bit r_cs;
        reset = 1'b1;
        valid_i = 0; start_i = 0; term_i = 0; term_len_i = 0; cancel_i = 0;
        cs_err_i = 0; data_i = 0; len_i = 2'd2;
        exp_src = 16'd0;
        idle(3);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_start", 32'(start_o), 0);
        chk("rst_term", 32'(term_o), 0);
        chk("rst_drop", 32'(drop_o), 0);
        chk("rst_cancel", 32'(cancel_o), 0);
        chk("rst_len_err", 32'(len_err_o), 0);
        chk("rst_src", 32'(src_port_o), 0);
        chk("rst_data", 32'(data_o), 0);
        reset = 1'b0;
        idle(2);

        // 1: basic packet
        pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        snap(); send_pkt(16'h1234, 16'd18000, 16'd12, 1'b0, 1'b0);
        check_pkt(16'h1234, 16'd18000, 16'd12, 1'b0, 0);

        // 2: wrong dst port, drop on the edge after the dst beat
        mk_pay(4);
        snap(); send_pkt(16'h5555, 16'd80, 16'd12, 1'b0, 1'b0);
        check_pkt(16'h5555, 16'd80, 16'd12, 1'b0, 0);
        chk("dst_drop_time", 32'(drop_cyc - st_cyc), 32'd1);

        // 3: checksum error on start beat, drop on the edge after start
        mk_pay(6);
        snap(); send_pkt(16'h7777, 16'd18000, 16'd14, 1'b1, 1'b0);
        check_pkt(16'h7777, 16'd18000, 16'd14, 1'b1, 0);
        chk("cs_drop_time", 32'(drop_cyc - st_cyc), 32'd0);

        // 4: odd payload, good and bad length
        pay = {8'h11, 8'h22, 8'h33};
        snap(); send_pkt(16'h0A0B, 16'd18000, 16'd11, 1'b0, 1'b1);
        check_pkt(16'h0A0B, 16'd18000, 16'd11, 1'b0, 0);
        snap(); send_pkt(16'h0C0D, 16'd18000, 16'd14, 1'b0, 1'b1);
        check_pkt(16'h0C0D, 16'd18000, 16'd14, 1'b0, 0);

        // truncated header and empty datagram
        snap();
        beat(1'b1, 1'b0, 2'd0, 16'h3412, 1'b0, 1'b0);
        beat(1'b0, 1'b1, 2'd2, 16'h5046, 1'b0, 1'b0);
        idle(3);
        chk("trunc_drop", 32'(n_drop - b_drop), 32'd1);
        chk("trunc_beats", 32'(mq.size() - b_mq), 32'd0);
        pay.delete();
        snap(); send_pkt(16'h9999, 16'd18000, 16'd8, 1'b0, 1'b0);
        check_pkt(16'h9999, 16'd18000, 16'd8, 1'b0, 0);

        // 5: cancel on the 2nd payload beat
        send_head(16'h4321, 16'd18000, 16'd12);
        beat(1'b0, 1'b0, 2'd0, 16'hBBAA, 1'b0, 1'b0);
        exp_src = 16'h4321;
        beat(1'b0, 1'b1, 2'd2, 16'hDDCC, 1'b0, 1'b1);
        chk("cancel_o", 32'(cancel_o), 32'd1);
        chk("cancel_valid", 32'(valid_o), 32'd0);
        idle(2);
        mk_pay(5);
        snap(); send_pkt(16'h2468, 16'd18000, 16'd13, 1'b0, 1'b0);
        check_pkt(16'h2468, 16'd18000, 16'd13, 1'b0, 0);

        // 6: async reset mid-DATA
        send_head(16'hBEEF, 16'd18000, 16'd16);
        beat(1'b0, 1'b0, 2'd0, 16'h2211, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_start", 32'(start_o), 0);
        chk("arst_data", 32'(data_o), 0);
        chk("arst_src", 32'(src_port_o), 0);
        exp_src = 16'd0;
        idle(1);
        reset = 1'b0;
        idle(1);
        mk_pay(4);
        snap(); send_pkt(16'h1357, 16'd18000, 16'd12, 1'b0, 1'b0);
        check_pkt(16'h1357, 16'd18000, 16'd12, 1'b0, 0);

        // start mid-DATA: cancel_o and the new packet parses
        send_head(16'h1111, 16'd18000, 16'd20);
        beat(1'b0, 1'b0, 2'd0, 16'h4433, 1'b0, 1'b0);
        exp_src = 16'h1111;
        idle(1);
        mk_pay(7);
        snap(); send_pkt(16'h2222, 16'd18000, 16'd15, 1'b0, 1'b0);
        check_pkt(16'h2222, 16'd18000, 16'd15, 1'b0, 1);

        // randomized packets
        for (int p = 0; p < 40; p++) begin
            np    = $urandom_range(0, 9);
            r_src = 16'($urandom);
            r_dst = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'd18000;
            r_cs  = ($urandom_range(0, 7) == 0);
            mode  = $urandom_range(0, 3);
            if (mode <= 1)      r_len = 16'(np + 8);
            else if (mode == 2) r_len = 16'($urandom_range(8, 30));
            else                r_len = 16'($urandom_range(0, 7));
            mk_pay(np);
            snap(); send_pkt(r_src, r_dst, r_len, r_cs, 1'b1);
            check_pkt(r_src, r_dst, r_len, r_cs, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
